// File: rtl/bp_reg_seq_pkg.sv
// Shared encodings for the layer register sequencer. The state and phase
// codes are also consumed by the top-level training FSM and debug monitors.
package bp_reg_seq_pkg;

   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_FWD  = 3'd1,
      S_BWD  = 3'd2,
      S_UPD  = 3'd3,
      S_DONE = 3'd4
   } state_t;

   localparam logic [1:0] PH_IDLE = 2'd0;
   localparam logic [1:0] PH_FWD  = 2'd1;
   localparam logic [1:0] PH_BWD  = 2'd2;
   localparam logic [1:0] PH_UPD  = 2'd3;

   // DONE reports the idle phase code so monitors see only the three passes.
   function automatic logic [1:0] phase_of(state_t s);
      case (s)
         S_FWD:   return PH_FWD;
         S_BWD:   return PH_BWD;
         S_UPD:   return PH_UPD;
         default: return PH_IDLE;
      endcase
   endfunction

endpackage

// File: rtl/bp_reg_seq_slot_cnt.sv
// Latency wait counter for one neuron slot. Counts 0..LAT and wraps,
// flagging the final (load) cycle of the slot through term.
module bp_slot_cnt #(
   parameter int LAT   = 2,
   parameter int CNT_W = 2
) (
   input  logic clk,
   input  logic rst,
   input  logic clr,
   input  logic en,
   output logic term
);

   logic [CNT_W-1:0] cnt;

   assign term = (cnt == CNT_W'(LAT));

   // Clear dominates; otherwise advance while enabled and wrap at the slot end.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt <= '0;
      end else if (clr) begin
         cnt <= '0;
      end else if (en) begin
         if (term) begin
            cnt <= '0;
         end else begin
            cnt <= cnt + CNT_W'(1);
         end
      end
   end

endmodule

// File: rtl/bp_reg_seq.sv
// Training-step sequencer for one layer: drives the shared datapath select
// through forward, backward and update passes and strobes the per-neuron
// storage registers. Moore outputs only.
module bp_reg_seq
   import bp_reg_seq_pkg::*;
#(
   parameter int N_NEURON = 4,
   parameter int LAT      = 2,
   parameter int IDX_W    = 2,
   parameter int CNT_W    = 2
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                start,
   input  logic                abort,
   output logic [IDX_W-1:0]    sel,
   output logic [1:0]          phase,
   output logic [N_NEURON-1:0] ld_act,
   output logic [N_NEURON-1:0] ld_err,
   output logic [N_NEURON-1:0] ld_w,
   output logic                busy,
   output logic                done
);

   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_NEURON - 1);

   state_t              state, state_n;
   logic [IDX_W-1:0]    idx, idx_n;
   logic                slot_end;
   logic                cnt_en;
   logic                cnt_clr;
   logic [N_NEURON-1:0] idx_onehot;

   assign cnt_en     = ((state == S_FWD) || (state == S_BWD)) && !abort;
   assign cnt_clr    = !cnt_en;
   assign idx_onehot = N_NEURON'(1) << idx;

   bp_slot_cnt #(
      .LAT   (LAT),
      .CNT_W (CNT_W)
   ) u_slot_cnt (
      .clk  (clk),
      .rst  (rst),
      .clr  (cnt_clr),
      .en   (cnt_en),
      .term (slot_end)
   );

   // State and neuron index registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= S_IDLE;
         idx   <= '0;
      end else begin
         state <= state_n;
         idx   <= idx_n;
      end
   end

   // Pass sequencing: index walks up in FWD/UPD, down in BWD; abort wins everywhere.
   always_comb begin
      state_n = state;
      idx_n   = idx;
      case (state)
         S_IDLE: begin
            if (start) begin
               state_n = S_FWD;
               idx_n   = '0;
            end
         end
         S_FWD: begin
            if (slot_end) begin
               if (idx == IDX_LAST) begin
                  state_n = S_BWD;
                  idx_n   = IDX_LAST;
               end else begin
                  idx_n = idx + IDX_W'(1);
               end
            end
         end
         S_BWD: begin
            if (slot_end) begin
               if (idx == '0) begin
                  state_n = S_UPD;
                  idx_n   = '0;
               end else begin
                  idx_n = idx - IDX_W'(1);
               end
            end
         end
         S_UPD: begin
            if (idx == IDX_LAST) begin
               state_n = S_DONE;
               idx_n   = '0;
            end else begin
               idx_n = idx + IDX_W'(1);
            end
         end
         S_DONE: begin
            state_n = S_IDLE;
            idx_n   = '0;
         end
         default: begin
            state_n = S_IDLE;
            idx_n   = '0;
         end
      endcase
      if (abort) begin
         state_n = S_IDLE;
         idx_n   = '0;
      end
   end

   // Output decode from registered state, index and slot terminal flag.
   always_comb begin
      sel    = '0;
      ld_act = '0;
      ld_err = '0;
      ld_w   = '0;
      busy   = 1'b0;
      done   = 1'b0;
      phase  = phase_of(state);
      case (state)
         S_FWD: begin
            sel  = idx;
            busy = 1'b1;
            if (slot_end) ld_act = idx_onehot;
         end
         S_BWD: begin
            sel  = idx;
            busy = 1'b1;
            if (slot_end) ld_err = idx_onehot;
         end
         S_UPD: begin
            sel  = idx;
            busy = 1'b1;
            ld_w = idx_onehot;
         end
         S_DONE: begin
            done = 1'b1;
         end
         default: begin
            sel = '0;
         end
      endcase
   end

endmodule

// File: tb/tb_bp_reg_seq.sv
// Bench for bp_reg_seq: two instances (LAT=2 and LAT=0) share stimulus and
// are compared each cycle against a position-in-step model, with literal
// pinned vectors for the nominal step and the asynchronous reset.
module tb_bp_reg_seq;

   localparam int N = 4;

   logic clk, rst, start, abort, probe, nom_on;
   int   cyc, nom_mark;
   int   vectors, miscompares;
   int   t1, t2;

   logic [1:0]   sel1, ph1, sel2, ph2;
   logic [N-1:0] act1, err1, w1, act2, err2, w2;
   logic         busy1, done1, busy2, done2;
   logic [17:0]  vec1, vec2;

   assign vec1 = {ph1, sel1, act1, err1, w1, busy1, done1};
   assign vec2 = {ph2, sel2, act2, err2, w2, busy2, done2};

   bp_reg_seq #(.N_NEURON(N), .LAT(2), .IDX_W(2), .CNT_W(2)) dut_lat2 (
      .clk(clk), .rst(rst), .start(start), .abort(abort),
      .sel(sel1), .phase(ph1), .ld_act(act1), .ld_err(err1), .ld_w(w1),
      .busy(busy1), .done(done1)
   );

   bp_reg_seq #(.N_NEURON(N), .LAT(0), .IDX_W(2), .CNT_W(1)) dut_lat0 (
      .clk(clk), .rst(rst), .start(start), .abort(abort),
      .sel(sel2), .phase(ph2), .ld_act(act2), .ld_err(err2), .ld_w(w2),
      .busy(busy2), .done(done2)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [17:0] pk(logic [1:0] ph, logic [1:0] s, logic [3:0] a,
                                      logic [3:0] e, logic [3:0] w, logic b, logic d);
      return {ph, s, a, e, w, b, d};
   endfunction

   function automatic int step_len(int lat);
      return 2 * N * (lat + 1) + N + 1;
   endfunction

   // Expected outputs from the position t inside a step (0 = idle).
   function automatic logic [17:0] expect_vec(int t, int lat);
      int f, u, slot;
      logic [1:0] ph, s;
      logic [3:0] a, e, w;
      logic b, d;
      f = N * (lat + 1);
      ph = 0; s = 0; a = 0; e = 0; w = 0; b = 0; d = 0;
      if (t >= 1 && t <= f) begin
         u = t - 1; slot = u / (lat + 1);
         ph = 2'd1; s = 2'(slot); b = 1;
         if (u % (lat + 1) == lat) a[slot] = 1'b1;
      end else if (t > f && t <= 2 * f) begin
         u = t - f - 1; slot = N - 1 - u / (lat + 1);
         ph = 2'd2; s = 2'(slot); b = 1;
         if (u % (lat + 1) == lat) e[slot] = 1'b1;
      end else if (t > 2 * f && t <= 2 * f + N) begin
         u = t - 2 * f - 1;
         ph = 2'd3; s = 2'(u); b = 1; w[u] = 1'b1;
      end else if (t == 2 * f + N + 1) begin
         d = 1;
      end
      return pk(ph, s, a, e, w, b, d);
   endfunction

   function automatic int next_t(int t, int lat, logic st, logic ab);
      if (ab) return 0;
      if (t == 0) return st ? 1 : 0;
      if (t == step_len(lat)) return 0;
      return t + 1;
   endfunction

   // Hand-computed vectors for the nominal step, LAT=2.
   function automatic logic [18:0] pin_lat2(int rel);
      case (rel)
         1:  return {1'b1, pk(2'd1, 2'd0, 4'b0000, 4'b0000, 4'b0000, 1, 0)};
         3:  return {1'b1, pk(2'd1, 2'd0, 4'b0001, 4'b0000, 4'b0000, 1, 0)};
         6:  return {1'b1, pk(2'd1, 2'd1, 4'b0010, 4'b0000, 4'b0000, 1, 0)};
         12: return {1'b1, pk(2'd1, 2'd3, 4'b1000, 4'b0000, 4'b0000, 1, 0)};
         13: return {1'b1, pk(2'd2, 2'd3, 4'b0000, 4'b0000, 4'b0000, 1, 0)};
         15: return {1'b1, pk(2'd2, 2'd3, 4'b0000, 4'b1000, 4'b0000, 1, 0)};
         24: return {1'b1, pk(2'd2, 2'd0, 4'b0000, 4'b0001, 4'b0000, 1, 0)};
         25: return {1'b1, pk(2'd3, 2'd0, 4'b0000, 4'b0000, 4'b0001, 1, 0)};
         28: return {1'b1, pk(2'd3, 2'd3, 4'b0000, 4'b0000, 4'b1000, 1, 0)};
         29: return {1'b1, pk(2'd0, 2'd0, 4'b0000, 4'b0000, 4'b0000, 0, 1)};
         30: return {1'b1, 18'd0};
         default: return '0;
      endcase
   endfunction

   // Hand-computed vectors for the nominal step, LAT=0.
   function automatic logic [18:0] pin_lat0(int rel);
      case (rel)
         1:  return {1'b1, pk(2'd1, 2'd0, 4'b0001, 4'b0000, 4'b0000, 1, 0)};
         4:  return {1'b1, pk(2'd1, 2'd3, 4'b1000, 4'b0000, 4'b0000, 1, 0)};
         5:  return {1'b1, pk(2'd2, 2'd3, 4'b0000, 4'b1000, 4'b0000, 1, 0)};
         8:  return {1'b1, pk(2'd2, 2'd0, 4'b0000, 4'b0001, 4'b0000, 1, 0)};
         9:  return {1'b1, pk(2'd3, 2'd0, 4'b0000, 4'b0000, 4'b0001, 1, 0)};
         12: return {1'b1, pk(2'd3, 2'd3, 4'b0000, 4'b0000, 4'b1000, 1, 0)};
         13: return {1'b1, pk(2'd0, 2'd0, 4'b0000, 4'b0000, 4'b0000, 0, 1)};
         14: return {1'b1, 18'd0};
         default: return '0;
      endcase
   endfunction

   task automatic checkOutput(string name, logic [17:0] got, logic [17:0] want);
      vectors++;
      if (got !== want) begin
         miscompares++;
         $display("[TB] FAIL %s cyc=%0d got=%h want=%h", name, cyc, got, want);
      end
   endtask

   // Free-running cycle counter used to time the pinned checks.
   always @(posedge clk) cyc <= cyc + 1;

   // Reference model: position inside the current step for each latency.
   always @(posedge clk or posedge rst) begin
      if (rst) begin
         t1 <= 0;
         t2 <= 0;
      end else begin
         t1 <= next_t(t1, 2, start, abort);
         t2 <= next_t(t2, 0, start, abort);
      end
   end

   // Single compare process: model every cycle, pins, strobe exclusivity, reset probe.
   always begin
      logic [18:0] p;
      @(negedge clk or posedge probe);
      if (probe) begin
         checkOutput("async_rst_lat2", vec1, 18'd0);
         checkOutput("async_rst_lat0", vec2, 18'd0);
      end else begin
         checkOutput("model_lat2", vec1, expect_vec(t1, 2));
         checkOutput("model_lat0", vec2, expect_vec(t2, 0));
         checkOutput("onehot_lat2", {17'd0, $countones({act1, err1, w1}) > 1}, 18'd0);
         checkOutput("onehot_lat0", {17'd0, $countones({act2, err2, w2}) > 1}, 18'd0);
         if (nom_on) begin
            p = pin_lat2(cyc - nom_mark);
            if (p[18]) checkOutput("pin_lat2", vec1, p[17:0]);
            p = pin_lat0(cyc - nom_mark);
            if (p[18]) checkOutput("pin_lat0", vec2, p[17:0]);
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic applyStimulus(logic s, logic a);
      start = s;
      abort = a;
      tick();
   endtask

   task automatic idle(int n);
      repeat (n) applyStimulus(1'b0, 1'b0);
   endtask

   initial begin
      cyc = 0; nom_mark = 0; vectors = 0; miscompares = 0;
      rst = 1'b1; start = 1'b0; abort = 1'b0; probe = 1'b0; nom_on = 1'b0;
      repeat (3) tick();
      rst = 1'b0;
      idle(2);

      // nominal step with pinned timing
      nom_mark = cyc;
      nom_on   = 1'b1;
      applyStimulus(1'b1, 1'b0);
      idle(32);
      nom_on = 1'b0;

      // start glitches mid-step and on the DONE cycle
      applyStimulus(1'b1, 1'b0);
      idle(4);
      applyStimulus(1'b1, 1'b0);
      idle(22);
      applyStimulus(1'b1, 1'b0);
      applyStimulus(1'b1, 1'b0);
      idle(5);

      // abort during the backward pass, then a clean step
      applyStimulus(1'b1, 1'b0);
      idle(12);
      applyStimulus(1'b0, 1'b1);
      idle(5);
      applyStimulus(1'b1, 1'b0);
      idle(32);

      // start and abort together in IDLE
      applyStimulus(1'b1, 1'b1);
      idle(3);

      // asynchronous reset mid-BWD, probed between clock edges
      applyStimulus(1'b1, 1'b0);
      idle(19);
      rst = 1'b1;
      #1 probe = 1'b1;
      #1 probe = 1'b0;
      tick();
      rst = 1'b0;
      idle(2);
      applyStimulus(1'b1, 1'b0);
      idle(32);

      // held-high start relaunches after each DONE
      repeat (70) applyStimulus(1'b1, 1'b0);
      idle(3);

      // randomized traffic with sparse aborts and resets
      for (int i = 0; i < 2500; i++) begin
         if ($urandom_range(0, 300) == 0) begin
            rst = 1'b1;
            tick();
            rst = 1'b0;
         end
         applyStimulus($urandom_range(0, 3) == 0, $urandom_range(0, 40) == 0);
      end
      idle(3);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/bp_reg_seq.md
Name: bp_reg_seq

Overview:
- Sequencer for one layer's bank of signed storage registers during a training step.
- Walks the shared neuron datapath through three passes: forward (activation capture), backward (error capture, reverse order) and weight update.
- Emits one-hot load strobes to the per-neuron storage registers and the neuron select to the shared datapath mux.
- Sits between the top-level training FSM (start/done) and the layer datapath.

Parameters:
- N_NEURON, 4, number of neurons/register slots in the layer (>=2).
- LAT, 2, pipeline latency in cycles from sel change to valid datapath result (>=0).
- IDX_W, 2, width of sel; must satisfy 2^IDX_W >= N_NEURON.
- CNT_W, 2, width of latency wait counter; must hold LAT.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-high.
- start  in  1  begin a training step; sampled only in IDLE.
- abort  in  1  synchronous cancel; returns to IDLE.
- sel  out  IDX_W  neuron index driven to the shared datapath.
- phase  out  2  0=IDLE/DONE, 1=FWD, 2=BWD, 3=UPD.
- ld_act  out  N_NEURON  one-hot activation-register load strobe.
- ld_err  out  N_NEURON  one-hot error-register load strobe.
- ld_w  out  N_NEURON  one-hot weight-register load strobe.
- busy  out  1  high in FWD, BWD, UPD.
- done  out  1  one-cycle pulse at the end of a completed step.

Behaviour:
- Reset (rst=1, async): state=IDLE, idx=0, wait counter=0. All outputs 0.
- Moore machine. Outputs decode from registered state, idx and wait counter only. No input-to-output combinational path.
- States:
  - IDLE: start=1 -> FWD with idx=0, cnt=0.
  - FWD: per-neuron slot of LAT+1 cycles; sel=idx. cnt counts 0..LAT. In the cycle where cnt==LAT, ld_act[idx]=1. Then cnt=0 and idx increments. After idx=N_NEURON-1's load cycle -> BWD with idx=N_NEURON-1.
  - BWD: same slot timing. idx decrements from N_NEURON-1 to 0. ld_err[idx]=1 in the cnt==LAT cycle. After idx=0's load cycle -> UPD with idx=0.
  - UPD: one cycle per neuron, no latency wait. ld_w[idx]=1 every cycle, idx 0..N_NEURON-1. After the last one -> DONE.
  - DONE: done=1, busy=0, phase=0, sel=0 for one cycle -> IDLE.
- Durations: FWD = N_NEURON*(LAT+1) cycles; BWD same; UPD = N_NEURON cycles; DONE = 1 cycle.
- At most one bit set across ld_act|ld_err|ld_w in any cycle. All strobes 0 in IDLE and DONE.
- start is ignored outside IDLE, including the DONE cycle. Held-high start in IDLE launches a new step on the first IDLE cycle after DONE.
- abort=1 in any state: next state IDLE, idx=0, cnt=0, no done pulse. Strobes in the abort cycle itself still follow the current state. abort takes precedence over start in IDLE.
- LAT=0: every FWD/BWD cycle is a load cycle.
- rst mid-step: immediate return to reset values; no partial done.
- sel holds the idx value throughout each slot. Datapath inputs are stable for the full LAT wait.

Decomposition:
- Shared package: state encoding constants (S_IDLE, S_FWD, S_BWD, S_UPD, S_DONE) and phase codes (PH_IDLE=0, PH_FWD=1, PH_BWD=2, PH_UPD=3), reused by the top-level training FSM and debug monitors.
- One natural sub-module: bp_slot_cnt, the LAT wait counter with terminal flag (clear, enable, cnt==LAT output).
- Index up/down counter and one-hot decode stay in bp_reg_seq.

Test Plan (N_NEURON=4, LAT=2; cycle 0 = edge where start is sampled in IDLE):
- Nominal step: start pulse -> ld_act[0..3] at cycles 3,6,9,12; ld_err[3..0] at 15,18,21,24; ld_w[0..3] at 25..28; done=1 only at 29; busy=1 cycles 1..28.
- Phase/sel trace, same run: phase=1 cycles 1-12, 2 cycles 13-24, 3 cycles 25-28, 0 at 29. sel=0 cycles 1-3 and 3 cycles 13-15.
- Abort: abort=1 at cycle 14 -> IDLE at 15; no ld_err[2], no done. Later start pulse -> full nominal step timing from that point.
- start glitches and simultaneous events: start pulses at cycles 5 and 29 ignored (only one done). start and abort together in IDLE -> stays IDLE.
- Async reset at cycle 20 (mid-BWD) -> all outputs 0 immediately, without a clock edge; phase=0; after release a new start gives nominal timing.
- LAT=0 build: start -> ld_act one bit per cycle, cycles 1-4; ld_err[3..0] cycles 5-8; ld_w cycles 9-12; done at 13; assertion checks one-hot/mutual exclusivity across all strobes.
